// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, fetch vs data, one transaction outstanding
module mem_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_gnt,
    output logic        imem_rvalid,
    output logic [31:0] imem_rdata,
    output logic        imem_error,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [3:0]  dmem_be,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_gnt,
    output logic        dmem_rvalid,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_DATA_BURST + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t        state, state_nxt;
    owner_t        owner;
    logic [CW-1:0] tcnt;
    logic [SW-1:0] streak;
    logic          grant_d, grant_i, timeout, resp_bus, complete;
    logic          rsp_err;
    logic [31:0]   rsp_data;

    always_comb begin
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        state_nxt = state;
        // Data wins unless fetch has already waited out a full data burst.
        if (state == IDLE && resetn) begin
            if (dmem_req && !(imem_req && streak == SW'(MAX_DATA_BURST)))
                grant_d = 1'b1;
            else if (imem_req)
                grant_i = 1'b1;
        end
        timeout  = (state != IDLE) && (tcnt == CW'(TIMEOUT - 1));
        resp_bus = (state == RESP) && bus_rvalid;
        complete = resetn && (resp_bus || timeout);
        rsp_err  = resp_bus ? bus_err : 1'b1;
        rsp_data = resp_bus ? bus_rdata : 32'h0;
        case (state)
            IDLE:    if (grant_d || grant_i) state_nxt = REQ;
            REQ:     if (timeout) state_nxt = IDLE;
                     else if (bus_ready) state_nxt = RESP;
            RESP:    if (complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            owner     <= OWN_FETCH;
            tcnt      <= '0;
            streak    <= '0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                owner     <= OWN_DATA;
                bus_we    <= dmem_we;
                bus_be    <= dmem_be;
                bus_addr  <= dmem_addr;
                bus_wdata <= dmem_wdata;
                tcnt      <= '0;
                if (!imem_req)
                    streak <= '0;
                else if (streak != SW'(MAX_DATA_BURST))
                    streak <= streak + SW'(1);
            end else if (grant_i) begin
                owner     <= OWN_FETCH;
                bus_we    <= 1'b0;
                bus_be    <= 4'b1111;
                bus_addr  <= imem_addr;
                bus_wdata <= 32'h0;
                tcnt      <= '0;
                streak    <= '0;
            end else if (state != IDLE && tcnt != CW'(TIMEOUT)) begin
                tcnt <= tcnt + CW'(1);
            end
        end
    end

    assign imem_gnt    = grant_i;
    assign dmem_gnt    = grant_d;
    assign bus_req     = (state == REQ) && !timeout && resetn;
    assign imem_rvalid = complete && (owner == OWN_FETCH);
    assign dmem_rvalid = complete && (owner == OWN_DATA);
    assign imem_error  = imem_rvalid && rsp_err;
    assign dmem_error  = dmem_rvalid && rsp_err;
    assign imem_rdata  = imem_rvalid ? rsp_data : 32'h0;
    assign dmem_rdata  = dmem_rvalid ? rsp_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid, imem_error;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid, dmem_error;
    logic [31:0] dmem_rdata;
    logic        bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ready, bus_rvalid, bus_err;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;
    int i_cnt  = 0;
    int d_cnt  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_DATA_BURST(4), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_error(imem_error),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always @(negedge clk) begin
        if (imem_rvalid) i_cnt++;
        if (dmem_rvalid) d_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    initial begin
        int          i0, d0;
        logic [9:0]  order;
        int          ngnt;

        resetn = 1'b0; imem_req = 1'b0; imem_addr = '0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_be = '0; dmem_addr = '0; dmem_wdata = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        step; step;
        settle;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_gnts", {30'd0, imem_gnt, dmem_gnt}, 32'd0);
        chk("rst_rvalids", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);

        // Single fetch
        step; resetn = 1'b1; imem_req = 1'b1; imem_addr = 32'h0000_0100;
        i0 = i_cnt; d0 = d_cnt;
        settle;
        chk("f_imem_gnt", 32'(imem_gnt), 32'd1);
        chk("f_dmem_gnt", 32'(dmem_gnt), 32'd0);
        step; imem_req = 1'b0; bus_ready = 1'b1;
        settle;
        chk("f_bus_req", 32'(bus_req), 32'd1);
        chk("f_bus_addr", bus_addr, 32'h0000_0100);
        chk("f_bus_be_we", {27'd0, bus_be, bus_we}, {27'd0, 4'b1111, 1'b0});
        step; bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        settle;
        chk("f_imem_rvalid", 32'(imem_rvalid), 32'd1);
        chk("f_imem_rdata", imem_rdata, 32'hDEAD_BEEF);
        chk("f_imem_error", 32'(imem_error), 32'd0);
        step; bus_rvalid = 1'b0; bus_rdata = '0;
        settle;
        chk("f_dmem_rv_count", 32'(d_cnt - d0), 32'd0);
        chk("f_imem_rv_count", 32'(i_cnt - i0), 32'd1);

        // Data write
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_be = 4'b0011;
        dmem_addr = 32'h0000_2000; dmem_wdata = 32'h1234_5678;
        i0 = i_cnt; d0 = d_cnt;
        #1;
        chk("w_dmem_gnt", 32'(dmem_gnt), 32'd1);
        chk("w_imem_gnt", 32'(imem_gnt), 32'd0);
        step; dmem_req = 1'b0; dmem_we = 1'b0; dmem_be = '0; dmem_wdata = '0; bus_ready = 1'b1;
        settle;
        chk("w_bus_req", 32'(bus_req), 32'd1);
        chk("w_bus_we_be", {27'd0, bus_be, bus_we}, {27'd0, 4'b0011, 1'b1});
        chk("w_bus_addr", bus_addr, 32'h0000_2000);
        chk("w_bus_wdata", bus_wdata, 32'h1234_5678);
        step; bus_ready = 1'b0; bus_rvalid = 1'b1;
        settle;
        chk("w_dmem_rvalid", 32'(dmem_rvalid), 32'd1);
        chk("w_imem_outs", {imem_rdata[29:0], imem_rvalid, imem_error}, 32'd0);
        step; bus_rvalid = 1'b0;
        settle;
        chk("w_dmem_rv_count", 32'(d_cnt - d0), 32'd1);
        chk("w_imem_rv_count", 32'(i_cnt - i0), 32'd0);

        // Continuous contention, zero-wait bus
        step; imem_req = 1'b1; dmem_req = 1'b1; bus_ready = 1'b1; bus_rvalid = 1'b1;
        imem_addr = 32'h0000_0400; dmem_addr = 32'h0000_0800;
        order = '0; ngnt = 0;
        for (int c = 0; c < 30; c++) begin
            settle;
            if (dmem_gnt || imem_gnt) begin
                order = {order[8:0], dmem_gnt};
                ngnt++;
            end
            step;
        end
        imem_req = 1'b0; dmem_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        chk("burst_grant_count", 32'(ngnt), 32'd10);
        chk("burst_grant_order", {22'd0, order}, {22'd0, 10'b1111011110});

        // Timeout with bus_ready stuck low
        settle;
        step; dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h0000_3000;
        d0 = d_cnt;
        settle;
        chk("t_dmem_gnt", 32'(dmem_gnt), 32'd1);
        for (int c = 1; c < 8; c++) begin
            step; dmem_req = 1'b0;
        end
        settle;
        chk("t_bus_req_c7", 32'(bus_req), 32'd1);
        chk("t_no_early_rv", 32'(d_cnt - d0), 32'd0);
        step;
        settle;
        chk("t_dmem_rvalid", 32'(dmem_rvalid), 32'd1);
        chk("t_dmem_error", 32'(dmem_error), 32'd1);
        chk("t_dmem_rdata", dmem_rdata, 32'h0);
        chk("t_bus_req_c8", 32'(bus_req), 32'd0);
        step; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0005;
        settle;
        chk("t_late_rv", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
        step; bus_rvalid = 1'b0; bus_rdata = '0;

        // Bus error on data read
        dmem_req = 1'b1; dmem_addr = 32'h0000_0040;
        settle;
        chk("e_dmem_gnt", 32'(dmem_gnt), 32'd1);
        step; dmem_req = 1'b0; bus_ready = 1'b1;
        step; bus_ready = 1'b0; bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'hAAAA_5555;
        settle;
        chk("e_dmem_rvalid", 32'(dmem_rvalid), 32'd1);
        chk("e_dmem_error", 32'(dmem_error), 32'd1);
        chk("e_dmem_rdata", dmem_rdata, 32'hAAAA_5555);
        step; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;

        // Reset while in RESP
        imem_req = 1'b1; imem_addr = 32'h0000_0500;
        i0 = i_cnt;
        settle;
        chk("r_imem_gnt", 32'(imem_gnt), 32'd1);
        step; imem_req = 1'b0; bus_ready = 1'b1;
        step; bus_ready = 1'b0; resetn = 1'b0;
        step; resetn = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        settle;
        chk("r_imem_rvalid", 32'(imem_rvalid), 32'd0);
        chk("r_bus_req", 32'(bus_req), 32'd0);
        chk("r_bus_addr", bus_addr, 32'h0);
        chk("r_bus_be", 32'(bus_be), 32'h0);
        step; bus_rvalid = 1'b0; bus_rdata = '0;
        dmem_req = 1'b1; dmem_addr = 32'h0000_0600;
        settle;
        chk("r_fresh_gnt", 32'(dmem_gnt), 32'd1);
        chk("r_no_rv", 32'(i_cnt - i0), 32'd0);
        step; dmem_req = 1'b0;
        settle;
        chk("r_fresh_addr", bus_addr, 32'h0000_0600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the core's instruction-fetch and data-access requesters. It serialises both onto one shared memory bus with at most one transaction outstanding. Data accesses have priority, with a bounded-burst rule so fetch is never starved. A response timeout guarantees every granted request completes. It sits between the core's fetch/memory stages and the external memory bus.

## Interface
Parameters:
- MAX_DATA_BURST, 4, consecutive data grants allowed while fetch is waiting; legal range ≥1.
- TIMEOUT, 255, cycles allowed from grant to bus response before an error response is forced; legal range ≥2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- imem_req  in  1  fetch request; held with imem_addr until imem_gnt.
- imem_addr  in  32  fetch address.
- imem_gnt  out  1  fetch request accepted this cycle.
- imem_rvalid  out  1  fetch response valid (one-cycle pulse).
- imem_rdata  out  32  fetch read data.
- imem_error  out  1  fetch response is an error (qualified by imem_rvalid).
- dmem_req  in  1  data request; held with its payload until dmem_gnt.
- dmem_we  in  1  data write enable.
- dmem_be  in  4  data byte enables.
- dmem_addr  in  32  data address.
- dmem_wdata  in  32  data write data.
- dmem_gnt, dmem_rvalid, dmem_rdata[32], dmem_error  out  -  as for imem; writes also return one rvalid.
- bus_req  out  1  request to memory; held until bus_ready.
- bus_we, bus_be[4], bus_addr[32], bus_wdata[32]  out  -  latched request payload; fetch drives we=0, be=4'b1111, wdata=0.
- bus_ready  in  1  memory accepts bus_req this cycle.
- bus_rvalid  in  1  memory response valid.
- bus_rdata  in  32  memory read data.
- bus_err  in  1  memory response error (qualified by bus_rvalid).

## Operation
- States: IDLE, REQ, RESP. Owner register records FETCH or DATA for the active transaction.
- IDLE: if any request is pending, grant exactly one. imem_gnt and dmem_gnt are combinational and mutually exclusive. On the grant edge: latch payload and owner, clear timeout counter, go to REQ.
- Selection: grant data if dmem_req, unless imem_req=1 and streak==MAX_DATA_BURST, in which case grant fetch. With only imem_req, grant fetch.
- Streak counter: increments on a data grant while imem_req=1. Clears on a fetch grant, or on a data grant while imem_req=0. Saturates at MAX_DATA_BURST.
- REQ: bus_req=1 with latched payload. bus_ready=1 → RESP on next edge.
- RESP: bus_req=0. bus_rvalid=1 → owner's rvalid=1 in the same cycle, rdata=bus_rdata, error=bus_err; go to IDLE.
- Non-owner rvalid/rdata/error are 0.
- Timeout: counter runs in REQ and RESP. On reaching TIMEOUT-1 without completion, the next cycle forces a response: owner rvalid=1, error=1, rdata=0; bus_req deasserts; go to IDLE.
- bus_rvalid in IDLE or REQ (late or spurious response) is ignored and not forwarded.
- Counter width: $clog2(TIMEOUT+1).

## Timing
- Reset (resetn=0 at edge): state IDLE, streak 0, counter 0. All outputs 0, including bus payload.
- Reset mid-transaction abandons the transaction; no rvalid is issued for it.
- Minimum transaction, with bus_ready and bus_rvalid both available at the earliest cycle:
  - cycle 0: grant.
  - cycle 1: bus_req, bus_ready=1.
  - cycle 2: RESP, bus_rvalid=1, requester rvalid.
  - cycle 3: next grant possible.
  - Peak throughput: one transaction per 3 cycles.
- Grant latency from req in IDLE is 0 cycles. Requests raised during REQ or RESP wait until IDLE.
- Simultaneous imem_req and dmem_req: data wins unless the streak is saturated.
- bus_rvalid and timeout in the same cycle: the bus response wins, with error=bus_err.
- bus_payload is stable for the whole REQ state.

## Test plan
- Single fetch, addr 0x0000_0100, bus_ready at 1st REQ cycle, bus_rvalid next cycle with 0xDEAD_BEEF → imem_gnt in cycle 0, bus_req/addr in cycle 1, imem_rvalid=1 and rdata=0xDEAD_BEEF in cycle 2, dmem_rvalid never 1.
- Data write we=1, be=4'b0011, addr 0x0000_2000, wdata 0x1234_5678 → bus payload matches exactly; one dmem_rvalid; imem outputs stay 0.
- imem_req and dmem_req held continuously, MAX_DATA_BURST=4, zero-wait bus → grant order D,D,D,D,F,D,D,D,D,F.
- bus_ready held 0, TIMEOUT=8 → owner rvalid=1, error=1, rdata=0 exactly 8 cycles after grant; a late bus_rvalid afterwards is not forwarded.
- bus_rvalid with bus_err=1 on a data read → dmem_rvalid=1, dmem_error=1 in the same cycle.
- resetn=0 during RESP → next cycle all outputs 0 and state IDLE; no rvalid; a fresh request afterwards is granted immediately.
